fir_mac_sequencer: RTL and testbench

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

---
 rtl/fir_mac_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
//   Sequences one FIR output per accepted ADC sample through an external MAC16.
//   Each accepted sample is shifted into an NTAPS-deep window. The FSM then
//   fetches the coefficients, streams NTAPS coefficient/sample pairs into the
//   MAC, waits MAC_LAT cycles for the accumulator to settle, and registers the
//   scaled result.
//
//   Optional feature: define FIR_SATURATE_EN to saturate y_out when the Q2.30
//   accumulator overflows the Q1.15 output range. Without it, y_out is a plain
//   truncation of the accumulator.
//
// Parameters
//   NTAPS    number of taps and depth of the sample window (2..128)
//   MAC_LAT  MAC16 latency from operand to mac_result (1..3)
//
// Ports
//   clk          sole clock; all state changes on the rising edge
//   reset        synchronous, active-low
//   sample_en    new-sample strobe; honoured only in IDLE
//   sample       24-bit ADC word; the window keeps sample[23:8]
//   tap_addr     coefficient ROM address
//   tap_coeff    signed Q1.15 coefficient, valid one cycle after tap_addr
//   mac_a        signed coefficient operand
//   mac_b        unsigned sample operand
//   mac_load     start a new accumulation with this product
//   mac_accum    add this product to the accumulator
//   mac_result   MAC16 accumulator output
//   y_out        filtered sample, held until the next result
//   y_valid      one-cycle strobe marking a new y_out
//   busy         high from FETCH through OUTPUT
//   overrun      sticky flag: a sample arrived while busy and was dropped
//   overrun_clr  clears overrun (a drop in the same cycle wins)
//
// Strobe semantics: there is no back-pressure. A sample_en seen in IDLE is
// always taken; a sample_en seen in any other state is dropped and flagged.
// y_valid is a single-cycle pulse with no acknowledge.
//
// The FSM state is held in the 'state' signal (type state_t) for observation.

module fir_mac_sequencer #(
  parameter int NTAPS   = 4,
  parameter int MAC_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_en,
  input  logic [23:0] sample,
  output logic [7:0]  tap_addr,
  input  logic [15:0] tap_coeff,
  output logic [15:0] mac_a,
  output logic [15:0] mac_b,
  output logic        mac_load,
  output logic        mac_accum,
  input  logic [31:0] mac_result,
  output logic [15:0] y_out,
  output logic        y_valid,
  output logic        busy,
  output logic        overrun,
  input  logic        overrun_clr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    MAC    = 3'd2,
    DRAIN  = 3'd3,
    OUTPUT = 3'd4
  } state_t;

  localparam int          IW         = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [7:0]  LAST_TAP   = 8'(NTAPS - 1);
  localparam logic [7:0]  LAST_DRAIN = 8'(MAC_LAT - 1);

  state_t        state;
  logic [15:0]   win [NTAPS];
  logic [7:0]    cnt;        // tap index in MAC, settle count in DRAIN
  logic [IW-1:0] nxt_idx;
  logic [15:0]   scaled;
  logic          in_mac;
  logic          unused;

  // Only the top 16 ADC bits are filtered; the Q1.15 result sits in [30:15].
  assign unused = ^{sample[7:0], mac_result[31], mac_result[14:0]};

  assign nxt_idx = cnt[IW-1:0] + IW'(1);

  // The ROM answers one cycle after tap_addr, which lines the coefficient up
  // with the registered sample operand, so mac_a is a gated pass-through.
  assign in_mac = (state == MAC);

  always_comb begin
    mac_a = 16'h0000;
    if (in_mac) mac_a = tap_coeff;
  end

  // Accumulator is Q2.30 (Q1.15 coefficient x unsigned sample); keep Q1.15.
  always_comb begin
    scaled = mac_result[30:15];
`ifdef FIR_SATURATE_EN
    if (mac_result[31] != mac_result[30])
      scaled = mac_result[31] ? 16'h8000 : 16'h7FFF;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      for (int i = 0; i < NTAPS; i++) win[i] <= 16'h0000;
      cnt       <= 8'd0;
      tap_addr  <= 8'd0;
      mac_b     <= 16'h0000;
      mac_load  <= 1'b0;
      mac_accum <= 1'b0;
      y_out     <= 16'h0000;
      y_valid   <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      y_valid <= 1'b0;

      // A drop in the same cycle as a clear leaves the flag set.
      if (sample_en && (state != IDLE)) overrun <= 1'b1;
      else if (overrun_clr)             overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (sample_en) begin
            for (int i = NTAPS - 1; i > 0; i--) win[i] <= win[i-1];
            win[0]   <= sample[23:8];
            tap_addr <= 8'd0;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end

        FETCH: begin
          cnt      <= 8'd0;
          tap_addr <= 8'd1;
          mac_load <= 1'b1;
          mac_b    <= win[0];
          state    <= MAC;
        end

        MAC: begin
          // Operands for tap cnt+1 are registered while tap cnt is on the bus.
          if (cnt == LAST_TAP) begin
            cnt       <= 8'd0;
            mac_load  <= 1'b0;
            mac_accum <= 1'b0;
            mac_b     <= 16'h0000;
            state     <= DRAIN;
          end else begin
            cnt       <= cnt + 8'd1;
            tap_addr  <= cnt + 8'd2;
            mac_load  <= 1'b0;
            mac_accum <= 1'b1;
            mac_b     <= win[nxt_idx];
          end
        end

        DRAIN: begin
          // The last product reaches mac_result in the final DRAIN cycle.
          if (cnt == LAST_DRAIN) begin
            y_out   <= scaled;
            y_valid <= 1'b1;
            state   <= OUTPUT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        OUTPUT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer
//   Directed bench for fir_mac_sequencer with NTAPS=4, MAC_LAT=2, a coefficient
//   ROM holding 16'h4000 everywhere and a behavioural MAC16 model. Cycle 0 is
//   the cycle in which sample_en is driven; each pass is checked cycle by cycle
//   through cycle 9, which doubles as cycle 0 of a back-to-back pass.

module tb_fir_mac_sequencer;

  localparam int NTAPS   = 4;
  localparam int MAC_LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sample_en;
  logic [23:0] sample;
  logic [7:0]  tap_addr;
  logic [15:0] tap_coeff;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic        mac_load;
  logic        mac_accum;
  logic [31:0] mac_result;
  logic [15:0] y_out;
  logic        y_valid;
  logic        busy;
  logic        overrun;
  logic        overrun_clr;

  fir_mac_sequencer #(.NTAPS(NTAPS), .MAC_LAT(MAC_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_en   (sample_en),
    .sample      (sample),
    .tap_addr    (tap_addr),
    .tap_coeff   (tap_coeff),
    .mac_a       (mac_a),
    .mac_b       (mac_b),
    .mac_load    (mac_load),
    .mac_accum   (mac_accum),
    .mac_result  (mac_result),
    .y_out       (y_out),
    .y_valid     (y_valid),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  // ---------------- coefficient ROM (1-cycle read) ----------------
  logic [15:0] rom_word = 16'h4000;
  always @(posedge clk) tap_coeff <= rom_word;

  // ---------------- MAC16 model, latency 2 ----------------
  logic signed [31:0] acc  = 32'sd0;
  logic signed [31:0] pipe = 32'sd0;
  logic signed [31:0] prod;
  logic               mac_force = 1'b0;
  logic [31:0]        force_val = 32'h0;

  assign prod = $signed(mac_a) * $signed({16'h0000, mac_b});

  always @(posedge clk) begin
    if (mac_load)       acc <= prod;
    else if (mac_accum) acc <= acc + prod;
    pipe <= acc;
  end

  assign mac_result = mac_force ? force_val : pipe;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full pass: sample driven in cycle 0, checks through cycle 9.
  // drop_cyc > 0 injects a sample_en (optionally with overrun_clr) in that cycle.
  task automatic run_pass(input string name, input logic [23:0] s,
                          input logic [15:0] b0, input logic [15:0] b1,
                          input logic [15:0] b2, input logic [15:0] b3,
                          input logic [15:0] ey, input int drop_cyc, input bit drop_clr);
    logic [15:0] eb [4];
    logic [15:0] ey_pop;
    eb = '{b0, b1, b2, b3};
    exp_q.push_back(ey);
    sample    = s;
    sample_en = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      sample_en   = 1'b0;
      overrun_clr = 1'b0;
      sample      = 24'h000000;
      if (c == 1) begin
        check($sformatf("%s c%0d busy", name, c), busy, 1);
        check($sformatf("%s c%0d tap_addr", name, c), tap_addr, 0);
        check($sformatf("%s c%0d load/accum", name, c), {mac_load, mac_accum}, 0);
        check($sformatf("%s c%0d mac_a/b", name, c), {mac_a, mac_b}, 0);
      end else if (c >= 2 && c <= 5) begin
        check($sformatf("%s c%0d tap_addr", name, c), tap_addr, c - 1);
        check($sformatf("%s c%0d mac_a", name, c), mac_a, 16'h4000);
        check($sformatf("%s c%0d mac_b", name, c), mac_b, eb[c-2]);
        check($sformatf("%s c%0d load/accum", name, c), {mac_load, mac_accum},
              (c == 2) ? 2'b10 : 2'b01);
      end else if (c == 6 || c == 7) begin
        check($sformatf("%s c%0d load/accum", name, c), {mac_load, mac_accum}, 0);
        check($sformatf("%s c%0d mac_a/b", name, c), {mac_a, mac_b}, 0);
        check($sformatf("%s c%0d tap_addr", name, c), tap_addr, 4);
        check($sformatf("%s c%0d busy/y_valid", name, c), {busy, y_valid}, 2'b10);
      end else if (c == 8) begin
        ey_pop = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check($sformatf("%s c%0d busy/y_valid", name, c), {busy, y_valid}, 2'b11);
        check($sformatf("%s c%0d y_out", name, c), y_out, ey_pop);
      end else begin
        check($sformatf("%s c%0d busy/y_valid", name, c), {busy, y_valid}, 2'b00);
        check($sformatf("%s c%0d y_out held", name, c), y_out, ey);
        check($sformatf("%s c%0d tap_addr held", name, c), tap_addr, 4);
      end
      if (drop_cyc > 0 && c == drop_cyc + 1)
        check($sformatf("%s c%0d overrun", name, c), overrun, 1);
      if (c == drop_cyc) begin
        sample      = 24'hFFFF00;
        sample_en   = 1'b1;
        overrun_clr = drop_clr;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] sat_exp;
  int          vld_seen;

  initial begin
    reset       = 1'b0;
    sample_en   = 1'b0;
    sample      = 24'h0;
    overrun_clr = 1'b0;

    // Reset held for two cycles.
    tick();
    tick();
    check("reset outputs",
          {tap_addr, mac_a, mac_b, mac_load, mac_accum, y_out, y_valid, busy, overrun}, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("idle %0d load/busy", i), {mac_load, mac_accum, busy}, 0);
    end

    // Single impulse: 0x0100 * 0x4000 = 0x0040_0000 -> y_out 0x0080.
    run_pass("impulse", 24'h010000, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0080, 0, 1'b0);

    // Reset in cycle 4 aborts the pass with no y_valid.
    sample    = 24'h010000;
    sample_en = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      sample_en = 1'b0;
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort c5 busy", busy, 0);
    check("abort c5 outputs", {mac_load, mac_accum, tap_addr, y_out, overrun}, 0);
    vld_seen = 0;
    for (int c = 6; c <= 11; c++) begin
      if (y_valid) vld_seen++;
      tick();
    end
    check("abort no y_valid", vld_seen, 0);
    // Window was cleared, so the impulse reproduces exactly.
    run_pass("impulse2", 24'h010000, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0080, 0, 1'b0);

    // Overrun: drop in cycle 3. (0x200+0x100)*0x4000 >> 15 = 0x180.
    run_pass("overrun", 24'h020000, 16'h0200, 16'h0100, 16'h0, 16'h0, 16'h0180, 3, 1'b0);
    // Dropped 0xFFFF must not appear in the window.
    run_pass("after drop", 24'h030000, 16'h0300, 16'h0200, 16'h0100, 16'h0, 16'h0300, 0, 1'b0);
    check("overrun sticky", overrun, 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("overrun cleared", overrun, 0);
    // Drop and clear in the same cycle: set wins. Sum 0x600*0x4000 >> 15 = 0x300.
    run_pass("set wins", 24'h000000, 16'h0000, 16'h0300, 16'h0200, 16'h0100, 16'h0300, 4, 1'b1);

    // Saturation on a forced accumulator of 0x4000_0000.
`ifdef FIR_SATURATE_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'h8000;
`endif
    mac_force = 1'b1;
    force_val = 32'h4000_0000;
    run_pass("saturate", 24'h000000, 16'h0000, 16'h0000, 16'h0300, 16'h0200, sat_exp, 0, 1'b0);
    mac_force = 1'b0;

    // Back-to-back passes from a cleared window.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("reset clears overrun", overrun, 0);
    run_pass("b2b first", 24'h000100, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0000, 0, 1'b0);
    run_pass("b2b second", 24'h000200, 16'h0002, 16'h0001, 16'h0, 16'h0, 16'h0001, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
